// File: rtl/fir_gain_mc.sv
// fir_gain_mc
//   Multi-channel, time-multiplexed FIR output gain stage. Each channel has a
//   floating-point-style gain 2^exp * (1 + mant/2^MANTW). The gain is applied to
//   the full-precision FIR result. The result is then optionally rounded (half up),
//   scaled down by 2^(MANTW+INW-OUTW) and saturated to OUTW bits.
//   Per-channel gains are double buffered: cfg_wr fills a shadow set, and
//   config_sync copies the whole shadow set to the active set in one edge.
//
//   Handshake: din_valid qualifies din/din_ch for exactly one edge. There is no
//   backpressure. dout_valid is a single-cycle strobe exactly 4 cycles after the
//   accepting edge. dout/dout_ch/dout_sat hold their values between strobes.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   cfg_wr/cfg_ch      write cfg_exp/cfg_mant into shadow gain of cfg_ch
//   cfg_exp/cfg_mant   gain exponent / mantissa fraction
//   config_sync        copy all shadow gains to the active gains
//   rnd_en             1 = round half up, 0 = floor (static)
//   din/din_ch         signed sample and its channel tag
//   din_valid          sample qualifier
//   sat_clr            clear sat_status (a coincident saturation still sets its bit)
//   dout/dout_ch       saturated result and its channel tag
//   dout_valid         result strobe
//   dout_sat           result was clipped
//   sat_status         sticky per-channel saturation flags
module fir_gain_mc #(
    parameter int NCH   = 4,
    parameter int INW   = 26,
    parameter int MANTW = 16,
    parameter int EXPW  = 4,
    parameter int OUTW  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_wr,
    input  logic [$clog2(NCH)-1:0]    cfg_ch,
    input  logic [EXPW-1:0]           cfg_exp,
    input  logic [MANTW-1:0]          cfg_mant,
    input  logic                      config_sync,
    input  logic                      rnd_en,
    input  logic signed [INW-1:0]     din,
    input  logic [$clog2(NCH)-1:0]    din_ch,
    input  logic                      din_valid,
    input  logic                      sat_clr,
    output logic signed [OUTW-1:0]    dout,
    output logic [$clog2(NCH)-1:0]    dout_ch,
    output logic                      dout_valid,
    output logic                      dout_sat,
    output logic [NCH-1:0]            sat_status
);
    localparam int CHW = $clog2(NCH);
    localparam int SH  = MANTW + INW - OUTW;        // final scale-down shift
    localparam int MW  = INW + MANTW + 1;           // din * (2^MANTW + mant)
    localparam int PW  = MW + (2 ** EXPW) - 1;      // after exponent shift
    localparam int SW  = PW + 1 - SH;               // scaled result, one guard bit for rounding
    localparam logic signed [PW:0] RND = (PW + 1)'(1) << (SH - 1);

    // ---------------- gain registers ----------------
    logic [EXPW-1:0]  shd_exp_q  [NCH];
    logic [MANTW-1:0] shd_mant_q [NCH];
    logic [EXPW-1:0]  act_exp_q  [NCH];
    logic [MANTW-1:0] act_mant_q [NCH];

    // The active set loads the shadow value held before this edge. So a cfg_wr on the
    // same edge lands only in the shadow register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                shd_exp_q[i]  <= '0;
                shd_mant_q[i] <= '0;
                act_exp_q[i]  <= '0;
                act_mant_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (config_sync) begin
                    act_exp_q[i]  <= shd_exp_q[i];
                    act_mant_q[i] <= shd_mant_q[i];
                end
                if (cfg_wr && cfg_ch == CHW'(i)) begin
                    shd_exp_q[i]  <= cfg_exp;
                    shd_mant_q[i] <= cfg_mant;
                end
            end
        end
    end

    // Tags beyond NCH can only occur when NCH is not a power of two.
    logic ch_ok;
    generate
        if (NCH == (2 ** CHW)) begin : g_ch_full
            assign ch_ok = 1'b1;
        end else begin : g_ch_part
            assign ch_ok = ({1'b0, din_ch} < (CHW + 1)'(NCH));
        end
    endgenerate

    logic [CHW-1:0] sel_ch;
    assign sel_ch = ch_ok ? din_ch : '0;

    // ---------------- pipeline registers ----------------
    logic                  s1_valid_q, s2_valid_q, s3_valid_q, s4_valid_q;
    logic [CHW-1:0]        s1_ch_q, s2_ch_q, s3_ch_q, s4_ch_q;
    logic signed [INW-1:0] s1_din_q;
    logic [EXPW-1:0]       s1_exp_q, s2_exp_q;
    logic [MANTW-1:0]      s1_mant_q;
    logic signed [MW-1:0]  s2_prod_q;
    logic signed [PW-1:0]  s3_p_q;
    logic signed [SW-1:0]  s4_s_q;

    logic signed [MANTW+1:0] gain_m;
    logic signed [MW-1:0]    s2_prod_d;
    logic signed [PW-1:0]    p_ext;
    logic signed [PW-1:0]    s3_p_d;
    logic signed [PW:0]      rnd_add;
    logic signed [PW:0]      p_rnd;
    logic signed [SW-1:0]    s4_s_d;

    always_comb begin
        // Mantissa factor 2^MANTW + mant as a positive signed operand.
        gain_m    = {1'b0, 1'b1, s1_mant_q};
        s2_prod_d = MW'(s1_din_q) * MW'(gain_m);
        p_ext     = PW'(s2_prod_q);
        s3_p_d    = p_ext <<< s2_exp_q;
        rnd_add   = '0;
        if (rnd_en) begin
            rnd_add = RND;
        end
        p_rnd  = (PW + 1)'(s3_p_q) + rnd_add;
        s4_s_d = SW'(p_rnd >>> SH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
            s4_valid_q <= 1'b0;
            s1_ch_q    <= '0;
            s2_ch_q    <= '0;
            s3_ch_q    <= '0;
            s4_ch_q    <= '0;
            s1_din_q   <= '0;
            s1_exp_q   <= '0;
            s1_mant_q  <= '0;
            s2_exp_q   <= '0;
            s2_prod_q  <= '0;
            s3_p_q     <= '0;
            s4_s_q     <= '0;
        end else begin
            // stage 1: input register and gain lookup
            s1_valid_q <= din_valid & ch_ok;
            s1_ch_q    <= din_ch;
            s1_din_q   <= din;
            s1_exp_q   <= act_exp_q[sel_ch];
            s1_mant_q  <= act_mant_q[sel_ch];
            // stage 2: mantissa multiply
            s2_valid_q <= s1_valid_q;
            s2_ch_q    <= s1_ch_q;
            s2_exp_q   <= s1_exp_q;
            s2_prod_q  <= s2_prod_d;
            // stage 3: exponent shift
            s3_valid_q <= s2_valid_q;
            s3_ch_q    <= s2_ch_q;
            s3_p_q     <= s3_p_d;
            // stage 4: round add and scale down (floor)
            s4_valid_q <= s3_valid_q;
            s4_ch_q    <= s3_ch_q;
            s4_s_q     <= s4_s_d;
        end
    end

    // ---------------- saturation and outputs ----------------
    logic [SW-OUTW:0]       hi_bits;
    logic                   sat_pos, sat_neg, sat_hit;
    logic signed [OUTW-1:0] sat_val;
    logic [NCH-1:0]         sat_status_d;

    always_comb begin
        // The value fits when every bit from OUTW-1 upward equals the sign.
        hi_bits = s4_s_q[SW-1:OUTW-1];
        sat_pos = ~s4_s_q[SW-1] & (|hi_bits);
        sat_neg = s4_s_q[SW-1] & ~(&hi_bits);
        sat_hit = sat_pos | sat_neg;
        sat_val = s4_s_q[OUTW-1:0];
        if (sat_pos) begin
            sat_val = {1'b0, {(OUTW-1){1'b1}}};
        end else if (sat_neg) begin
            sat_val = {1'b1, {(OUTW-1){1'b0}}};
        end
        // Clear first, then set, so a same-edge saturation keeps its bit.
        sat_status_d = sat_clr ? '0 : sat_status;
        for (int i = 0; i < NCH; i++) begin
            if (s4_valid_q && sat_hit && s4_ch_q == CHW'(i)) begin
                sat_status_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout       <= '0;
            dout_ch    <= '0;
            dout_valid <= 1'b0;
            dout_sat   <= 1'b0;
            sat_status <= '0;
        end else begin
            dout_valid <= s4_valid_q;
            if (s4_valid_q) begin
                dout     <= sat_val;
                dout_ch  <= s4_ch_q;
                dout_sat <= sat_hit;
            end
            sat_status <= sat_status_d;
        end
    end

endmodule

// File: tb/tb_fir_gain_mc.sv
// Testbench for fir_gain_mc. A behavioural model computes each sample's result
// with plain integer arithmetic when the sample is accepted. The result is then
// delayed by the 4-cycle latency. A compare process checks every DUT output against
// the model on every falling edge. Directed checks against literal values pin
// both the model and the DUT.
module tb_fir_gain_mc;
  localparam int NCH   = 4;
  localparam int INW   = 26;
  localparam int MANTW = 16;
  localparam int EXPW  = 4;
  localparam int OUTW  = 16;
  localparam int CHW   = 2;
  localparam int SH    = MANTW + INW - OUTW;
  localparam int LAT   = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                   cfg_wr = 1'b0;
  logic [CHW-1:0]         cfg_ch = '0;
  logic [EXPW-1:0]        cfg_exp = '0;
  logic [MANTW-1:0]       cfg_mant = '0;
  logic                   config_sync = 1'b0;
  logic                   rnd_en = 1'b0;
  logic signed [INW-1:0]  din = '0;
  logic [CHW-1:0]         din_ch = '0;
  logic                   din_valid = 1'b0;
  logic                   sat_clr = 1'b0;
  logic signed [OUTW-1:0] dout;
  logic [CHW-1:0]         dout_ch;
  logic                   dout_valid;
  logic                   dout_sat;
  logic [NCH-1:0]         sat_status;

  fir_gain_mc #(.NCH(NCH), .INW(INW), .MANTW(MANTW), .EXPW(EXPW), .OUTW(OUTW)) dut (
    .clk(clk), .rst(rst),
    .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_exp(cfg_exp), .cfg_mant(cfg_mant),
    .config_sync(config_sync), .rnd_en(rnd_en),
    .din(din), .din_ch(din_ch), .din_valid(din_valid), .sat_clr(sat_clr),
    .dout(dout), .dout_ch(dout_ch), .dout_valid(dout_valid),
    .dout_sat(dout_sat), .sat_status(sat_status)
  );

  int n_cmp = 0;
  int n_mis = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input longint act, input longint expv);
    n_cmp++;
    if (act !== expv) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // y = sat(floor((din * (2^MANTW + mant) * 2^exp [+ 2^(SH-1)]) / 2^SH))
  task automatic ref_calc(input longint x, input int e, input int m, input bit rnd,
                          output longint y, output bit sat);
    longint p;
    longint s;
    p = x * ((longint'(1) << MANTW) + longint'(m)) * (longint'(1) << e);
    if (rnd) p = p + (longint'(1) << (SH - 1));
    s = p >>> SH;
    sat = 1'b0;
    y = s;
    if (s > 32767) begin y = 32767; sat = 1'b1; end
    if (s < -32768) begin y = -32768; sat = 1'b1; end
  endtask

  int     m_shd_e [NCH];
  int     m_shd_m [NCH];
  int     m_act_e [NCH];
  int     m_act_m [NCH];
  // Results in flight; index LAT-1 is the sample due at this edge.
  bit     p_v  [LAT];
  int     p_ch [LAT];
  longint p_y  [LAT];
  bit     p_s  [LAT];
  bit     m_valid;
  longint m_dout;
  int     m_ch;
  bit     m_sat;
  logic [NCH-1:0] m_st;
  bit     o_v;
  int     o_ch;
  longint o_y;
  bit     o_s;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        m_shd_e[i] = 0; m_shd_m[i] = 0; m_act_e[i] = 0; m_act_m[i] = 0;
      end
      for (int i = 0; i < LAT; i++) p_v[i] = 1'b0;
      m_valid = 1'b0; m_dout = 0; m_ch = 0; m_sat = 1'b0; m_st = '0;
    end else begin
      o_v = p_v[LAT-1]; o_ch = p_ch[LAT-1]; o_y = p_y[LAT-1]; o_s = p_s[LAT-1];
      for (int i = LAT - 1; i > 0; i--) begin
        p_v[i] = p_v[i-1]; p_ch[i] = p_ch[i-1]; p_y[i] = p_y[i-1]; p_s[i] = p_s[i-1];
      end
      p_v[0] = din_valid && (int'(din_ch) < NCH);
      p_ch[0] = int'(din_ch);
      p_y[0] = 0; p_s[0] = 1'b0;
      if (p_v[0])
        ref_calc(longint'(din), m_act_e[din_ch], m_act_m[din_ch], rnd_en, p_y[0], p_s[0]);
      // gains used above are the pre-edge active set
      if (config_sync)
        for (int i = 0; i < NCH; i++) begin m_act_e[i] = m_shd_e[i]; m_act_m[i] = m_shd_m[i]; end
      if (cfg_wr) begin m_shd_e[cfg_ch] = int'(cfg_exp); m_shd_m[cfg_ch] = int'(cfg_mant); end
      if (sat_clr) m_st = '0;
      m_valid = o_v;
      if (o_v) begin
        m_dout = o_y; m_ch = o_ch; m_sat = o_s;
        if (o_s) m_st[o_ch] = 1'b1;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp_valid", longint'(dout_valid), longint'(m_valid));
      chk("cmp_dout", longint'(dout), m_dout);
      chk("cmp_ch", longint'(dout_ch), longint'(m_ch));
      chk("cmp_sat", longint'(dout_sat), longint'(m_sat));
      chk("cmp_status", longint'(sat_status), longint'(m_st));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int cycles);
    @(posedge clk); #1;
    rst = 1'b1; din_valid = 1'b0; cfg_wr = 1'b0; config_sync = 1'b0; sat_clr = 1'b0;
    repeat (cycles) @(posedge clk);
    chk_en = 1'b1;
    #1 rst = 1'b0;
  endtask

  task automatic cfg(input int ch, input int e, input int m);
    @(posedge clk); #1;
    cfg_wr = 1'b1; cfg_ch = CHW'(ch); cfg_exp = EXPW'(e); cfg_mant = MANTW'(m);
    @(posedge clk); #1;
    cfg_wr = 1'b0;
  endtask

  task automatic do_sync();
    @(posedge clk); #1 config_sync = 1'b1;
    @(posedge clk); #1 config_sync = 1'b0;
  endtask

  // One sample, then check the strobe exactly LAT edges after acceptance.
  task automatic send_chk(input string nm, input int x, input int ch,
                          input int exp_y, input bit exp_sat);
    @(posedge clk); #1;
    din_valid = 1'b1; din = INW'(x); din_ch = CHW'(ch);
    @(posedge clk); #1;
    din_valid = 1'b0;
    repeat (LAT) @(posedge clk);
    @(negedge clk);
    chk({nm, "_valid"}, longint'(dout_valid), 1);
    chk({nm, "_dout"}, longint'(dout), longint'(exp_y));
    chk({nm, "_ch"}, longint'(dout_ch), longint'(ch));
    chk({nm, "_sat"}, longint'(dout_sat), longint'(exp_sat));
  endtask

  longint ly;
  bit     ls;
  logic [31:0] r;
  logic signed [INW-1:0] rtmp;

  initial begin
    // model pins
    ref_calc(1024, 0, 0, 1'b0, ly, ls);          chk("model_unity", ly, 1);
    ref_calc(-102400, 1, 32768, 1'b0, ly, ls);   chk("model_gain3", ly, -300);
    ref_calc(33554431, 0, 0, 1'b1, ly, ls);      chk("model_sat", ly + longint'(ls), 32768);
    ref_calc(-512, 0, 0, 1'b1, ly, ls);          chk("model_rnd", ly, 0);

    do_reset(3);
    @(negedge clk);
    chk("rst_dout", longint'(dout), 0);
    chk("rst_valid", longint'(dout_valid), 0);
    chk("rst_status", longint'(sat_status), 0);

    send_chk("unity", 1024, 0, 1, 1'b0);
    cfg(2, 1, 32768);
    do_sync();
    send_chk("gain3_ch2", -102400, 2, -300, 1'b0);
    send_chk("gain1_ch1", -102400, 1, -100, 1'b0);

    rnd_en = 1'b0;
    send_chk("max_trunc", 33554431, 0, 32767, 1'b0);
    rnd_en = 1'b1;
    send_chk("max_rnd", 33554431, 0, 32767, 1'b1);
    chk("max_rnd_status0", longint'(sat_status[0]), 1);

    @(posedge clk); #1 sat_clr = 1'b1;
    @(posedge clk); #1 sat_clr = 1'b0;
    rnd_en = 1'b0;
    send_chk("m513_trunc", -513, 0, -1, 1'b0);
    send_chk("m512_trunc", -512, 0, -1, 1'b0);
    rnd_en = 1'b1;
    send_chk("m513_rnd", -513, 0, -1, 1'b0);
    send_chk("m512_rnd", -512, 0, 0, 1'b0);
    rnd_en = 1'b0;

    // shadow write without sync leaves gain 1; sync edge sample still old gain
    cfg(3, 1, 0);
    send_chk("shadow_only", 1024, 3, 1, 1'b0);
    @(posedge clk); #1;
    din_valid = 1'b1; din = 1024; din_ch = 3; config_sync = 1'b1;
    @(posedge clk); #1;
    config_sync = 1'b0;
    @(posedge clk); #1;
    din_valid = 1'b0;
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk);
    chk("sync_edge_old", longint'(dout), 1);
    chk("sync_edge_old_v", longint'(dout_valid), 1);
    @(negedge clk);
    chk("sync_next_new", longint'(dout), 2);
    chk("sync_next_new_v", longint'(dout_valid), 1);

    // sat_clr coincident with saturation on ch1: bit stays set
    cfg(1, 4, 0);
    do_sync();
    @(posedge clk); #1;
    din_valid = 1'b1; din = 8000000; din_ch = 1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    repeat (LAT - 1) @(posedge clk);
    #1 sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    @(negedge clk);
    chk("clr_vs_sat_status", longint'(sat_status), 2);
    chk("clr_vs_sat_dout", longint'(dout), 32767);

    // mid-stream reset flush
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      din_valid = 1'b1; din = INW'(1000 * (i + 1)); din_ch = CHW'(i);
    end
    do_reset(1);
    for (int i = 0; i < LAT + 1; i++) begin
      @(negedge clk);
      chk("flush_no_valid", longint'(dout_valid), 0);
    end

    // randomized traffic, one segment per rounding mode
    for (int seg = 0; seg < 2; seg++) begin
      @(posedge clk); #1;
      din_valid = 1'b0; rnd_en = seg[0];
      repeat (LAT + 2) @(posedge clk);
      for (int c = 0; c < 900; c++) begin
        @(posedge clk); #1;
        r = $urandom;
        rtmp = r[INW-1:0];
        din_valid = ($urandom_range(0, 3) != 0);
        din_ch = CHW'($urandom_range(0, NCH - 1));
        din = rtmp >>> $urandom_range(0, INW - 1);
        cfg_wr = ($urandom_range(0, 11) == 0);
        cfg_ch = CHW'($urandom_range(0, NCH - 1));
        cfg_exp = EXPW'($urandom_range(0, 15) < 12 ? $urandom_range(0, 3) : $urandom_range(0, 15));
        cfg_mant = MANTW'($urandom);
        config_sync = ($urandom_range(0, 23) == 0);
        sat_clr = ($urandom_range(0, 29) == 0);
        rst = (c == 450 || c == 451);
      end
      @(posedge clk); #1;
      din_valid = 1'b0; cfg_wr = 1'b0; config_sync = 1'b0; sat_clr = 1'b0; rst = 1'b0;
      repeat (LAT + 2) @(posedge clk);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
